// File: rtl/branch_predictor_if.sv
// Lookup/training bus between the pipeline and the branch predictor.
// Lookup:   pc_if in, pred_taken / pred_target out (combinational).
// Training: ex_update, ex_pc, ex_taken, ex_target from the EX stage.
// master = pipeline side, slave = predictor side.
interface branch_predictor_if;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_update;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;

  modport master (
    output pc_if, ex_update, ex_pc, ex_taken, ex_target,
    input  pred_taken, pred_target
  );

  modport slave (
    input  pc_if, ex_update, ex_pc, ex_taken, ex_target,
    output pred_taken, pred_target
  );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 2-bit saturating BHT plus direct-mapped BTB,
// combinational prediction from the IF PC, a two-stage {valid, idx}
// metadata pipe (IF->ID->EX) gated by predict_en and flushed on
// missprediction, training from the EX stage, saturating perf counters.
// Ports: clk, rst (async, active-high), predict_en, missprediction,
//        bus (branch_predictor_if.slave), br_count, mispred_count.
// Optional: define BP_GLOBAL_HISTORY_EN for gshare indexing (GHR XOR PC).
module branch_predictor #(
  parameter int unsigned BHT_IDX_W = 6,
  parameter int unsigned BTB_IDX_W = 5,
  parameter int unsigned GHR_W     = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                predict_en,
  input  logic                missprediction,
  branch_predictor_if.slave   bus,
  output logic [31:0]         br_count,
  output logic [31:0]         mispred_count
);

  localparam int unsigned BHT_N = 1 << BHT_IDX_W;
  localparam int unsigned BTB_N = 1 << BTB_IDX_W;
  localparam int unsigned TAG_W = 30 - BTB_IDX_W;

  typedef struct packed {
    logic                 valid;
    logic [BHT_IDX_W-1:0] idx;
  } meta_t;

  logic [1:0]       bht        [BHT_N];
  logic             btb_valid  [BTB_N];
  logic [TAG_W-1:0] btb_tag    [BTB_N];
  logic [31:0]      btb_target [BTB_N];

  meta_t                meta_id;
  meta_t                meta_ex;
  logic [BHT_IDX_W-1:0] idx_if;
  logic [BTB_IDX_W-1:0] btb_idx_if;
  logic [BTB_IDX_W-1:0] btb_idx_ex;
  logic                 btb_hit;
  logic                 train;
  logic                 unused_bits;

  // Byte-offset bits are never used; GHR_W must not exceed BHT_IDX_W.
  assign unused_bits = ^{bus.pc_if[1:0], bus.ex_pc[1:0]} ^ (GHR_W > BHT_IDX_W);

  assign train      = bus.ex_update && meta_ex.valid;
  assign btb_idx_if = bus.pc_if[BTB_IDX_W+1:2];
  assign btb_idx_ex = bus.ex_pc[BTB_IDX_W+1:2];

`ifdef BP_GLOBAL_HISTORY_EN
  logic [GHR_W-1:0] ghr;

  // Non-speculative history: shifts only on resolved, trained branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ghr <= '0;
    else if (train) ghr <= GHR_W'({ghr, bus.ex_taken});
  end

  assign idx_if = bus.pc_if[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr);
`else
  assign idx_if = bus.pc_if[BHT_IDX_W+1:2];
`endif

  // Prediction path; reads see pre-update state (no bypass).
  always_comb begin
    btb_hit         = btb_valid[btb_idx_if] &&
                      (btb_tag[btb_idx_if] == bus.pc_if[31:BTB_IDX_W+2]);
    bus.pred_taken  = btb_hit && bht[idx_if][1];
    bus.pred_target = btb_hit ? btb_target[btb_idx_if] : bus.pc_if + 32'd4;
  end

  // Metadata pipe; flush clears valids and wins over advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_id <= '0;
      meta_ex <= '0;
    end else begin
      if (predict_en) begin
        meta_id <= {1'b1, idx_if};
        meta_ex <= meta_id;
      end
      if (missprediction) begin
        meta_id.valid <= 1'b0;
        meta_ex.valid <= 1'b0;
      end
    end
  end

  // BHT saturating counters, reset weakly not-taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (train) begin
      if (bus.ex_taken && bht[meta_ex.idx] != 2'b11)
        bht[meta_ex.idx] <= bht[meta_ex.idx] + 2'd1;
      else if (!bus.ex_taken && bht[meta_ex.idx] != 2'b00)
        bht[meta_ex.idx] <= bht[meta_ex.idx] - 2'd1;
    end
  end

  // BTB valid bits; only taken branches allocate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
    end else if (train && bus.ex_taken) begin
      btb_valid[btb_idx_ex] <= 1'b1;
    end
  end

  // BTB payload needs no reset: it is qualified by btb_valid.
  always_ff @(posedge clk) begin
    if (train && bus.ex_taken) begin
      btb_tag[btb_idx_ex]    <= bus.ex_pc[31:BTB_IDX_W+2];
      btb_target[btb_idx_ex] <= bus.ex_target;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (train && br_count != 32'hFFFF_FFFF)
        br_count <= br_count + 32'd1;
      if (missprediction && mispred_count != 32'hFFFF_FFFF)
        mispred_count <= mispred_count + 32'd1;
    end
  end

endmodule
